// File: rtl/sysid_regs.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_regs
//  Description : Avalon-MM system identification register block. Provides a
//                read-only ID word and build timestamp, a free-running 64-bit
//                cycle counter with a coherent upper-word snapshot, a control
//                register (enable / self-clearing clear) and NUM_SCRATCH
//                general purpose scratch registers.
//  Ports       : clock          - sole clock, rising edge
//                reset          - asynchronous active-high reset
//                address[2:0]   - word address
//                read / write   - single-cycle access strobes
//                writedata[31:0], byteenable[3:0] - write data and lanes
//                readdata[31:0] - registered read data (1-cycle latency)
//                readdatavalid  - one-cycle pulse qualifying readdata
//  Address map : 0 ID, 1 TIMESTAMP, 2 CNT_LO, 3 CNT_HI, 4 CTRL,
//                5.. SCRATCH0..SCRATCH(NUM_SCRATCH-1), others read as zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_regs #(
    parameter logic [31:0] ID_VALUE    = 32'h4FD4_A1E9,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 2            // legal range 1..3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] c_ADDR_ID      = 3'd0;
    localparam logic [2:0] c_ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] c_ADDR_CNT_LO  = 3'd2;
    localparam logic [2:0] c_ADDR_CNT_HI  = 3'd3;
    localparam logic [2:0] c_ADDR_CTRL    = 3'd4;
    localparam logic [2:0] c_SCRATCH_BASE = 3'd5;

    logic [63:0] r_counter;
    logic [31:0] r_snapshot;
    logic        r_ctrl_en;
    logic [31:0] w_scratch [NUM_SCRATCH];

    // A simultaneous read and write services only the read.
    logic w_wr_en;
    logic w_wr_ctrl;
    logic w_clear;
    logic w_rd_cnt_lo;
    logic [31:0] w_rdata;

    assign w_wr_en     = write & ~read;
    assign w_wr_ctrl   = w_wr_en & (address == c_ADDR_CTRL);
    // Clear is a pulse derived straight from the write; it is never stored,
    // so CTRL[1] always reads back as zero.
    assign w_clear     = w_wr_ctrl & byteenable[0] & writedata[1];
    assign w_rd_cnt_lo = read & (address == c_ADDR_CNT_LO);

    // ------------------------------------------------------------------
    // Control register: only bit 0 (counter enable) has storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl_en <= 1'b1;
        end else if (w_wr_ctrl && byteenable[0]) begin
            r_ctrl_en <= writedata[0];
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter. Clear wins over increment; wraps silently.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_counter <= 64'd0;
        end else if (w_clear) begin
            r_counter <= 64'd0;
        end else if (r_ctrl_en) begin
            r_counter <= r_counter + 64'd1;
        end
    end

    // Upper word is captured when the lower word is read so that a
    // LO-then-HI read pair is coherent across a carry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snapshot <= 32'd0;
        end else if (w_rd_cnt_lo) begin
            r_snapshot <= r_counter[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Scratch registers with byte-lane write enables.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
            logic [31:0] r_word;
            logic        w_sel;

            assign w_sel = w_wr_en & (address == (c_SCRATCH_BASE + 3'(gi)));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_word <= 32'd0;
                end else if (w_sel) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            r_word[8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end

            assign w_scratch[gi] = r_word;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux; unmapped addresses fall through to zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 32'd0;
        case (address)
            c_ADDR_ID:     w_rdata = ID_VALUE;
            c_ADDR_TSTAMP: w_rdata = TIMESTAMP;
            c_ADDR_CNT_LO: w_rdata = r_counter[31:0];
            c_ADDR_CNT_HI: w_rdata = r_snapshot;
            c_ADDR_CTRL:   w_rdata = {31'd0, r_ctrl_en};
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == (c_SCRATCH_BASE + 3'(i))) begin
                        w_rdata = w_scratch[i];
                    end
                end
            end
        endcase
    end

    // readdata holds its last value between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= w_rdata;
            end
        end
    end

endmodule
`default_nettype wire
